interrupt_controller: RTL and testbench

//   Fixed-priority interrupt controller in front of the 8-bit processor's single interrupt input.
//   - Collects NUM_SRC peripheral interrupt sources (timer, LED blinker, GPIO, ...).
//   - Edge-detects, latches and masks them.
//   - Presents one request to the core with an ack/EOI handshake and supplies a vector.
//   - One interrupt in service at a time; no nesting.

---
 rtl/interrupt_controller_pkg.sv | 22 ++
 rtl/interrupt_controller_prio_enc.sv | 19 +
 rtl/interrupt_controller.sv | 104 ++++++++++
 tb/tb_interrupt_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared types and helpers for the fixed-priority interrupt controller.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_e;

    localparam logic [7:0] VEC_BASE_DEF = 8'hF0;
    localparam logic [7:0] VEC_STEP_DEF = 8'h02;

    // Vector arithmetic wraps modulo 256 by construction.
    function automatic logic [7:0] vec_addr(
        input logic [7:0] base,
        input logic [7:0] step,
        input logic [2:0] id
    );
        return base + ({5'd0, id} * step);
    endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Lowest-index-wins priority encoder for interrupt requests.
module irq_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic               valid_o,
    output logic [2:0]         idx_o
);

    always_comb begin
        idx_o = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = 3'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detecting, maskable interrupt controller with ack/EOI handshake
// and one interrupt in service at a time.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int         NUM_SRC  = 4,
    parameter logic [7:0] VEC_BASE = VEC_BASE_DEF,
    parameter logic [7:0] VEC_STEP = VEC_STEP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               cpu_ack,
    input  logic               eoi,
    output logic               cpu_irq,
    output logic [7:0]         vector,
    output logic [2:0]         active_id,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] prev_q, pend_q, pend_d, mask_q;
    logic [NUM_SRC-1:0] evt, req, clr;
    logic [7:0]         vec_q, vec_d;
    logic [2:0]         id_q, id_d;
    logic               busy_q, busy_d;
    logic               win_vld;
    logic [2:0]         win;

    assign evt = src_irq & ~prev_q;
    assign req = pend_q & ~mask_q;

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
        .req_i   (req),
        .valid_o (win_vld),
        .idx_o   (win)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        id_d    = id_q;
        busy_d  = busy_q;
        clr     = '0;
        unique case (state_q)
            IRQ_IDLE: begin
                if (win_vld) state_d = IRQ_REQ;
            end
            IRQ_REQ: begin
                if (!win_vld) begin
                    state_d = IRQ_IDLE;
                end else if (cpu_ack) begin
                    state_d = IRQ_SVC;
                    id_d    = win;
                    vec_d   = vec_addr(VEC_BASE, VEC_STEP, win);
                    busy_d  = 1'b1;
                    clr     = NUM_SRC'(1) << win;
                end
            end
            IRQ_SVC: begin
                if (eoi) begin
                    state_d = IRQ_IDLE;
                    busy_d  = 1'b0;
                    vec_d   = 8'h00;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
        // A new event on the winner in its ack cycle survives the clear.
        pend_d = (pend_q & ~clr) | evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IRQ_IDLE;
            pend_q  <= '0;
            mask_q  <= '1;
            prev_q  <= '1;
            vec_q   <= 8'h00;
            id_q    <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= src_irq;
            vec_q   <= vec_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign cpu_irq   = (state_q == IRQ_REQ);
    assign vector    = vec_q;
    assign active_id = id_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign mask      = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized checks of interrupt_controller against a
// behavioural model of the controller rules.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] src_irq = 4'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = 4'b0;
    logic       cpu_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       cpu_irq;
    logic [7:0] vector;
    logic [2:0] active_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] mask;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model state: mode 0 = idle, 1 = requesting, 2 = in service
    int       m_mode = 0;
    bit [3:0] m_pend, m_mask, m_prev;
    int       m_vec, m_id;
    bit       m_busy;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .src_irq    (src_irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .cpu_ack    (cpu_ack),
        .eoi        (eoi),
        .cpu_irq    (cpu_irq),
        .vector     (vector),
        .active_id  (active_id),
        .busy       (busy),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic int lowest_req();
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && !m_mask[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        bit [3:0] ev;
        if (reset) begin
            m_mode = 0; m_pend = 4'b0; m_mask = 4'hF; m_prev = 4'hF;
            m_vec = 0; m_id = 0; m_busy = 0;
            return;
        end
        w = lowest_req();
        ev = 4'b0;
        for (int i = 0; i < 4; i++)
            ev[i] = src_irq[i] && !m_prev[i];
        if (m_mode == 0) begin
            if (w >= 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (w < 0) m_mode = 0;
            else if (cpu_ack) begin
                m_mode = 2;
                m_id = w;
                m_vec = (240 + w * 2) % 256;
                m_busy = 1;
                m_pend[w] = 1'b0;
            end
        end else if (eoi) begin
            m_mode = 0;
            m_busy = 0;
            m_vec = 0;
        end
        m_pend = m_pend | ev;
        m_prev = src_irq;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic step(input logic [3:0] s, input bit we = 0,
                        input logic [3:0] wd = 4'b0, input bit ack = 0,
                        input bit e = 0, input bit r = 0);
        src_irq = s; mask_we = we; mask_wdata = wd;
        cpu_ack = ack; eoi = e; reset = r;
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_irq", {7'b0, cpu_irq}, {7'b0, m_mode == 1});
            check("vector", vector, 8'(m_vec));
            check("active_id", {5'b0, active_id}, 8'(m_id));
            check("busy", {7'b0, busy}, {7'b0, m_busy});
            check("pending", {4'b0, pending}, {4'b0, m_pend});
            check("mask", {4'b0, mask}, {4'b0, m_mask});
        end
    end

    initial begin
        // 1: single source, full handshake
        step(4'b0000, 0, 4'b0, 0, 0, 1);
        check("rst_cpu_irq", {7'b0, cpu_irq}, 8'h00);
        check("rst_mask", {4'b0, mask}, 8'h0F);
        check("rst_pending", {4'b0, pending}, 8'h00);
        check("rst_vector", vector, 8'h00);
        step(4'b0000, 1, 4'b0000);
        step(4'b0100);
        check("t1_pend", {4'b0, pending}, 8'h04);
        check("t1_irq_lo", {7'b0, cpu_irq}, 8'h00);
        step(4'b0100);
        check("t1_irq_hi", {7'b0, cpu_irq}, 8'h01);
        step(4'b0100, 0, 4'b0, 1);
        check("t1_vec", vector, 8'hF4);
        check("t1_id", {5'b0, active_id}, 8'h02);
        check("t1_busy", {7'b0, busy}, 8'h01);
        step(4'b0100, 0, 4'b0, 0, 1);
        check("t1_eoi_busy", {7'b0, busy}, 8'h00);
        check("t1_eoi_vec", vector, 8'h00);
        // 2: simultaneous sources, priority order
        step(4'b1110);
        check("t2_pend", {4'b0, pending}, 8'h0A);
        step(4'b1110);
        step(4'b1110, 0, 4'b0, 1);
        check("t2_vec1", vector, 8'hF2);
        check("t2_id1", {5'b0, active_id}, 8'h01);
        step(4'b1110, 0, 4'b0, 0, 1);
        check("t2_idle", {7'b0, cpu_irq}, 8'h00);
        step(4'b1110);
        check("t2_req", {7'b0, cpu_irq}, 8'h01);
        step(4'b1110, 0, 4'b0, 1);
        check("t2_vec3", vector, 8'hF6);
        check("t2_id3", {5'b0, active_id}, 8'h03);
        step(4'b0000, 0, 4'b0, 0, 1);
        // 3: masked source latches but does not request
        step(4'b0000, 1, 4'b0001);
        step(4'b0001);
        check("t3_pend", {4'b0, pending}, 8'h01);
        step(4'b0001);
        step(4'b0001);
        check("t3_masked", {7'b0, cpu_irq}, 8'h00);
        step(4'b0001, 1, 4'b0000);
        check("t3_irq_lo", {7'b0, cpu_irq}, 8'h00);
        step(4'b0001);
        check("t3_irq_hi", {7'b0, cpu_irq}, 8'h01);
        step(4'b0001, 0, 4'b0, 1);
        check("t3_vec", vector, 8'hF0);
        step(4'b0001, 0, 4'b0, 0, 1);
        // 4: request withdrawn by masking before ack
        step(4'b0011);
        step(4'b0011);
        check("t4_req", {7'b0, cpu_irq}, 8'h01);
        step(4'b0011, 1, 4'b0010);
        step(4'b0011);
        check("t4_drop", {7'b0, cpu_irq}, 8'h00);
        check("t4_pend", {4'b0, pending}, 8'h02);
        check("t4_busy", {7'b0, busy}, 8'h00);
        step(4'b0011, 1, 4'b0000);
        step(4'b0011);
        step(4'b0011, 0, 4'b0, 1);
        step(4'b0011, 0, 4'b0, 0, 1);
        // 5: re-edge of winner in its own ack cycle is kept
        step(4'b0010);
        step(4'b0011);
        step(4'b0010);
        check("t5_req", {7'b0, cpu_irq}, 8'h01);
        step(4'b0011, 0, 4'b0, 1);
        check("t5_keep", {4'b0, pending}, 8'h01);
        check("t5_id", {5'b0, active_id}, 8'h00);
        step(4'b0011, 0, 4'b0, 0, 1);
        step(4'b0011);
        check("t5_req2", {7'b0, cpu_irq}, 8'h01);
        step(4'b0011, 0, 4'b0, 1);
        check("t5_clear", {4'b0, pending}, 8'h00);
        step(4'b0011, 0, 4'b0, 0, 1);
        // 6: reset in service, then stray handshakes
        step(4'b0010);
        step(4'b1011);
        step(4'b1011);
        step(4'b1011, 0, 4'b0, 1);
        check("t6_svc_pend", {4'b0, pending}, 8'h08);
        check("t6_svc_busy", {7'b0, busy}, 8'h01);
        step(4'b1011, 0, 4'b0, 0, 0, 1);
        check("t6_rst_busy", {7'b0, busy}, 8'h00);
        check("t6_rst_pend", {4'b0, pending}, 8'h00);
        check("t6_rst_vec", vector, 8'h00);
        check("t6_rst_mask", {4'b0, mask}, 8'h0F);
        step(4'b1011, 0, 4'b0, 1);
        step(4'b1011, 0, 4'b0, 0, 1);
        check("t6_stray", {7'b0, cpu_irq}, 8'h00);
        check("t6_stray_busy", {7'b0, busy}, 8'h00);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] s;
            s = src_irq;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) s[i] = ~s[i];
            step(s,
                 $urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
